// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader
// and the instruction memory it fills.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int MEM_BYTES_DEF  = 64;

endpackage

// File: rtl/instruction_loader_if.sv
// Word source / memory-write bundle of the instruction loader.
// master = word source side, slave = the loader itself.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = $clog2(MEM_BYTES / BYTES_PER_WORD) + 1;

    logic          Start;
    logic [AW-1:0] BaseAddr;
    logic [31:0]   WordIn;
    logic          WordValid;
    logic          Last;
    logic          WordReady;
    logic          InsMemRW;
    logic [31:0]   IAddr;
    logic [7:0]    IDataOut;
    logic          Busy;
    logic          Done;
    logic          Overflow;
    logic [CW-1:0] WordCount;

    modport master (
        output Start, BaseAddr, WordIn, WordValid, Last,
        input  WordReady, InsMemRW, IAddr, IDataOut,
        input  Busy, Done, Overflow, WordCount
    );

    modport slave (
        input  Start, BaseAddr, WordIn, WordValid, Last,
        output WordReady, InsMemRW, IAddr, IDataOut,
        output Busy, Done, Overflow, WordCount
    );

endinterface

// File: rtl/instruction_loader_byte_serializer.sv
// Splits a 32-bit word into four bytes, MSB first.
// The register drains to zero after the fourth byte.
module byte_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] word,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0] sreg;
    logic [1:0]  idx;

    // Capture a new word, or move the next byte into the top slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= word;
            idx  <= '0;
        end else if (shift) begin
            sreg <= {sreg[23:0], 8'h00};
            idx  <= idx + 2'd1;
        end
    end

    assign byte_out  = sreg[31:24];
    assign last_byte = (idx == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a stream of 32-bit instruction words into a
// byte-wide instruction memory, big-endian, with wrap.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input logic           CLK,
    input logic           Reset,
    instruction_loader_if.slave bus
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = $clog2(MEM_BYTES / BYTES_PER_WORD) + 1;
    localparam logic [CW-1:0] WORDS = CW'(MEM_BYTES / BYTES_PER_WORD);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          last_q;
    logic          ovf_q;
    logic          ready_q;
    logic          rw_q;
    logic          busy_q;
    logic          done_q;
    logic          hs;
    logic          full;
    logic          last_byte;
    logic [7:0]    byte_out;

    assign hs        = ready_q & bus.WordValid;
    assign count_inc = count + CW'(1);
    assign full      = (count_inc == WORDS);

    byte_serializer u_ser (
        .clk      (CLK),
        .rst_n    (Reset),
        .load     (hs),
        .shift    (state == S_WRITE),
        .word     (bus.WordIn),
        .byte_out (byte_out),
        .last_byte(last_byte)
    );

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state: Last beats a full memory when both coincide
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (bus.Start) state_next = S_ACCEPT;
            S_ACCEPT: if (hs) state_next = S_WRITE;
            S_WRITE: begin
                if (last_byte) begin
                    if (last_q || full) state_next = S_DONE;
                    else                state_next = S_ACCEPT;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered outputs and session datapath
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr     <= '0;
            count   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (state_next == S_ACCEPT);
            rw_q    <= (state_next == S_WRITE);
            busy_q  <= (state_next != S_IDLE);
            done_q  <= (state_next == S_DONE);
            if (state == S_IDLE && bus.Start) begin
                ptr   <= bus.BaseAddr & ~AW'(3);
                count <= '0;
                ovf_q <= 1'b0;
            end
            if (hs) last_q <= bus.Last;
            if (state == S_WRITE) begin
                ptr <= ptr + AW'(1);
                if (last_byte) begin
                    count <= count_inc;
                    if (!last_q && full) ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.WordReady = ready_q;
    assign bus.InsMemRW  = rw_q;
    assign bus.IAddr     = {{(32 - AW){1'b0}}, ptr};
    assign bus.IDataOut  = byte_out;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Overflow  = ovf_q;
    assign bus.WordCount = count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: table of
// single-word sessions plus multi-cycle corner cases.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    logic CLK = 1'b0;
    logic Reset;

    instruction_loader_if bus ();

    instruction_loader dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    always @(posedge CLK) cyc = cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          c;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] src_words[$];

    always @(negedge CLK)
        if (bus.InsMemRW === 1'b1)
            wr_q.push_back('{bus.IAddr, bus.IDataOut, cyc});

    typedef struct {
        logic [5:0]  base;
        logic [31:0] word;
        logic [31:0] a0;
        logic [7:0]  b [4];
    } vec_t;

    vec_t vecs[4];

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; Start is seen at the next posedge
    task automatic do_start(string tag, logic [5:0] base);
        bus.Start    = 1'b1;
        bus.BaseAddr = base;
        @(negedge CLK);
        bus.Start = 1'b0;
        check({tag, "_ready"}, 32'(bus.WordReady), 32'd1);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
        check({tag, "_cnt0"}, 32'(bus.WordCount), 32'd0);
        check({tag, "_ovf0"}, 32'(bus.Overflow), 32'd0);
    endtask

    task automatic send_words(string tag, int n, bit last_final,
                              bit rand_valid);
        for (int k = 0; k < n; k++) begin
            bit accepted = 0;
            int budget   = 0;
            bus.WordIn = src_words[k];
            bus.Last   = last_final && (k == n - 1);
            while (!accepted && budget < 60) begin
                bus.WordValid = rand_valid ?
                    1'($urandom_range(0, 1)) : 1'b1;
                if (bus.WordValid && bus.WordReady) begin
                    accepted = 1;
                    hs_cyc   = cyc;
                end
                @(negedge CLK);
                budget++;
            end
            if (!accepted) begin
                check({tag, "_hs_timeout"}, 32'd0, 32'd1);
                bus.WordValid = 1'b0;
                return;
            end
        end
        bus.WordValid = 1'b0;
        bus.Last      = 1'b0;
    endtask

    task automatic wait_done(string tag, int exp_cnt, bit exp_ovf);
        int b      = 0;
        int rdy_hi = 0;
        while (bus.Done !== 1'b1 && b < 40) begin
            if (bus.WordReady === 1'b1) rdy_hi++;
            @(negedge CLK);
            b++;
        end
        check({tag, "_done"}, 32'(bus.Done), 32'd1);
        check({tag, "_lat"}, 32'(cyc - hs_cyc), 32'd5);
        check({tag, "_noready"}, 32'(rdy_hi), 32'd0);
        check({tag, "_cnt"}, 32'(bus.WordCount), 32'(exp_cnt));
        check({tag, "_ovf"}, 32'(bus.Overflow), 32'(exp_ovf));
        @(negedge CLK);
        check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        check({tag, "_idle"}, 32'(bus.Busy), 32'd0);
    endtask

    task automatic compare_writes(string tag, int base, int n);
        int nb = n * 4;
        int a0 = base - (base % 4);
        check({tag, "_nwr"}, 32'(wr_q.size()), 32'(nb));
        for (int i = 0; i < nb && i < wr_q.size(); i++) begin
            logic [31:0] w  = src_words[i / 4];
            logic [31:0] ea = 32'((a0 + i) % 64);
            logic [7:0]  ed = 8'(w >> (24 - 8 * (i % 4)));
            check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, ea);
            check($sformatf("%s_data%0d", tag, i),
                  32'(wr_q[i].data), 32'(ed));
        end
        if (wr_q.size() >= nb && nb > 0)
            check({tag, "_wr_lat"}, 32'(wr_q[nb - 4].c - hs_cyc),
                  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{6'd0,  32'h8C220004, 32'd0,
                    '{8'h8C, 8'h22, 8'h00, 8'h04}};
        vecs[1] = '{6'd6,  32'hDEADBEEF, 32'd4,
                    '{8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[2] = '{6'd63, 32'h01234567, 32'd60,
                    '{8'h01, 8'h23, 8'h45, 8'h67}};
        vecs[3] = '{6'd33, 32'hFFFFFFFF, 32'd32,
                    '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};

        bus.Start     = 1'b0;
        bus.BaseAddr  = '0;
        bus.WordIn    = '0;
        bus.WordValid = 1'b0;
        bus.Last      = 1'b0;
        Reset         = 1'b0;
        #1;
        check("rst_rw", 32'(bus.InsMemRW), 32'd0);
        check("rst_ready", 32'(bus.WordReady), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_ovf", 32'(bus.Overflow), 32'd0);
        check("rst_data", 32'(bus.IDataOut), 32'd0);
        check("rst_addr", bus.IAddr, 32'd0);
        check("rst_cnt", 32'(bus.WordCount), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            string t = $sformatf("vec%0d", v);
            wr_q.delete();
            src_words = '{vecs[v].word};
            do_start(t, vecs[v].base);
            send_words(t, 1, 1'b1, 1'b0);
            wait_done(t, 1, 1'b0);
            check({t, "_nwr"}, 32'(wr_q.size()), 32'd4);
            for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
                check($sformatf("%s_addr%0d", t, i), wr_q[i].addr,
                      vecs[v].a0 + 32'(i));
                check($sformatf("%s_byte%0d", t, i),
                      32'(wr_q[i].data), 32'(vecs[v].b[i]));
            end
        end

        wr_q.delete();
        src_words = '{32'h11223344, 32'h55667788};
        do_start("wrap", 6'd62);
        send_words("wrap", 2, 1'b1, 1'b0);
        wait_done("wrap", 2, 1'b0);
        compare_writes("wrap", 62, 2);
        if (wr_q.size() >= 5) begin
            check("wrap_first", wr_q[0].addr, 32'd60);
            check("wrap_second", wr_q[4].addr, 32'd0);
        end

        wr_q.delete();
        src_words.delete();
        for (int k = 0; k < 16; k++)
            src_words.push_back(32'h03020100 + 32'(k) * 32'h04040404);
        do_start("ovf", 6'd0);
        send_words("ovf", 16, 1'b0, 1'b0);
        wait_done("ovf", 16, 1'b1);
        compare_writes("ovf", 0, 16);
        repeat (3) @(negedge CLK);
        check("ovf_held", 32'(bus.Overflow), 32'd1);

        wr_q.delete();
        src_words = '{32'hA0A1A2A3, 32'hB0B1B2B3,
                      32'hC0C1C2C3, 32'hD0D1D2D3};
        do_start("rnd", 6'd16);
        send_words("rnd", 4, 1'b1, 1'b1);
        wait_done("rnd", 4, 1'b0);
        compare_writes("rnd", 16, 4);

        wr_q.delete();
        src_words = '{32'hCAFEF00D};
        do_start("rstw", 6'd8);
        send_words("rstw", 1, 1'b1, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        check("rstw_b2_rw", 32'(bus.InsMemRW), 32'd1);
        check("rstw_b2_data", 32'(bus.IDataOut), 32'h00F0);
        check("rstw_b2_addr", bus.IAddr, 32'd10);
        #2;
        Reset = 1'b0;
        #1;
        check("rstw_rw", 32'(bus.InsMemRW), 32'd0);
        check("rstw_busy", 32'(bus.Busy), 32'd0);
        check("rstw_ready", 32'(bus.WordReady), 32'd0);
        check("rstw_addr", bus.IAddr, 32'd0);
        check("rstw_data", 32'(bus.IDataOut), 32'd0);
        check("rstw_cnt", 32'(bus.WordCount), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        wr_q.delete();
        src_words = '{32'h0BADBEEF};
        do_start("rstn", 6'd21);
        send_words("rstn", 1, 1'b1, 1'b0);
        wait_done("rstn", 1, 1'b0);
        compare_writes("rstn", 21, 1);

        wr_q.delete();
        src_words = '{32'hA1B2C3D4, 32'h0F1E2D3C};
        do_start("sbusy", 6'd0);
        fork
            send_words("sbusy", 2, 1'b1, 1'b0);
            begin
                repeat (2) @(negedge CLK);
                bus.Start    = 1'b1;
                bus.BaseAddr = 6'd40;
                @(negedge CLK);
                bus.Start = 1'b0;
            end
        join
        wait_done("sbusy", 2, 1'b0);
        compare_writes("sbusy", 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, instruction-memory size in bytes; a multiple of 4 and a power of two.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  begin a load session; sampled only in IDLE.
REQ-005 SHALL have port BaseAddr  input  6  session start byte address; bits [1:0] ignored (forced 0).
REQ-006 SHALL have port WordIn  input  32  instruction word to store.
REQ-007 SHALL have port WordValid  input  1  WordIn/Last valid.
REQ-008 SHALL have port Last  input  1  accompanying word is the final word of the session.
REQ-009 SHALL have port WordReady  output  1  loader can accept a word this cycle.
REQ-010 SHALL have port InsMemRW  output  1  memory write strobe; 1=write, 0=read.
REQ-011 SHALL have port IAddr  output  32  memory byte address; upper bits zero.
REQ-012 SHALL have port IDataOut  output  8  byte to write.
REQ-013 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port Done  output  1  one-cycle pulse at session end.
REQ-015 SHALL have port Overflow  output  1  last session ended on capacity, not on Last; held until next Start.
REQ-016 SHALL have port WordCount  output  5..log2(MEM_BYTES/4)+1 bits  words written this session.

Function
REQ-017 SHALL implement FSM IDLE, ACCEPT, WRITE, DONE; all outputs driven from registers.
REQ-018 IDLE: Start=1 -> ACCEPT; ptr<=BaseAddr & ~3; WordCount<=0; Overflow<=0. Start ignored in all other states.
REQ-019 ACCEPT: WordReady=1; handshake WordValid&WordReady latches WordIn and Last, -> WRITE with byte index 0.
REQ-020 WRITE: four consecutive cycles, InsMemRW=1, IAddr=ptr, IDataOut = word byte i, big-endian (i=0 -> bits 31:24, i=3 -> bits 7:0); ptr increments each cycle.
REQ-021 ptr SHALL wrap modulo MEM_BYTES (address MEM_BYTES-1 followed by 0).
REQ-022 After byte 3: WordCount+=1; Last=1 -> DONE; else WordCount==MEM_BYTES/4 -> DONE with Overflow<=1; else -> ACCEPT.
REQ-023 Latency: word accepted in cycle N -> bytes written N+1..N+4 -> WordReady or Done in N+5; peak throughput one word per 5 cycles.
REQ-024 DONE: Done=1 for exactly one cycle, -> IDLE unconditionally.
REQ-025 Outside WRITE: InsMemRW=0, IDataOut=0, IAddr holds last ptr value.
REQ-026 WordValid while WordReady=0 SHALL NOT be consumed; source must hold data until handshake.

Reset
REQ-027 Reset low SHALL immediately force IDLE, InsMemRW=0, WordReady=0, Busy=0, Done=0, Overflow=0, IDataOut=0, IAddr=0, WordCount=0, including mid-WRITE (a partial word is abandoned).
REQ-028 First Start honoured on the first rising edge after Reset deasserts.

Structure
REQ-029 Shared package SHALL hold the state enum, BYTES_PER_WORD=4 and default MEM_BYTES, shared with the instruction memory.
REQ-030 Word-to-byte MSB-first shifting SHALL live in one sub-module, byte_serializer (load word, shift out 4 bytes, flag last byte).

Verification
REQ-031 Start, BaseAddr=0, one word 0x8C220004 with Last=1 -> writes 0x8C,0x22,0x00,0x04 at IAddr 0..3, Done in cycle N+5, WordCount=1, Overflow=0.
REQ-032 BaseAddr=62 -> first write at IAddr 60 (aligned); second word written at 0..3 (wrap).
REQ-033 16 words with Last=0, BaseAddr=0 -> 64 bytes written, Done with Overflow=1, WordCount=16, WordReady never high after word 16.
REQ-034 WordValid toggling randomly in ACCEPT -> only handshaked words written, in order, no duplicates.
REQ-035 Reset low during byte 2 of a word -> InsMemRW=0 the same cycle, FSM in IDLE; a following Start restarts cleanly at new BaseAddr.
REQ-036 Start pulsed while Busy -> ignored; ptr and WordCount unaffected.
